// File: rtl/w_encoder_velocity_calc.sv
// Encoder position front end: wrap-aware signed delta, 16-deep speed window,
// revolution count, sample timeout, plausibility and error accounting.
module w_encoder_velocity_calc #(
  parameter int unsigned TIMEOUT_CYC = 12500,
  parameter int unsigned JUMP_LIM    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        motion_en,
  input  logic        cfg_spindle_width_i,
  input  logic        pos_en_i,
  input  logic [31:0] pos_i,
  input  logic        pos_error_i,
  input  logic        pos_warn_i,
  output logic        delta_en_o,
  output logic [31:0] delta_o,
  output logic        speed_en_o,
  output logic [31:0] speed_o,
  output logic [15:0] rev_cnt_o,
  output logic        stale_o,
  output logic        jump_err_o,
  output logic [7:0]  err_cnt_o,
  output logic        warn_o
);
  localparam int unsigned PW  = 26;
  localparam int unsigned DW  = 32;
  localparam int unsigned WIN = 16;
  localparam int unsigned FW  = 5;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, PRIME, TRACK, FAULT} state_t;

  state_t          state_q, state_d;
  logic            cfg_q, cfg_d;
  logic [PW-1:0]   prev_q, prev_d;
  logic [DW-1:0]   win_q [WIN];
  logic [DW-1:0]   win_d [WIN];
  logic [DW-1:0]   sum_q, sum_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            spd_pend_q, spd_pend_d;
  logic            delta_en_q, delta_en_d;
  logic [DW-1:0]   delta_q, delta_d;
  logic            speed_en_q, speed_en_d;
  logic [DW-1:0]   speed_q, speed_d;
  logic [15:0]     rev_q, rev_d;
  logic            stale_q, stale_d;
  logic            jump_q, jump_d;
  logic [7:0]      err_q, err_d;
  logic            warn_q, warn_d;

  logic [PW-1:0]   pos_m;
  logic [PW-1:0]   diff;
  logic [DW-1:0]   d_ext;
  logic [DW-1:0]   d_mag;
  logic            is_jump;
  logic            accept;
  logic            reject;
  logic            cfg_chg;
  logic            clr_win;
  logic            unused_pos;

  assign unused_pos = ^pos_i[31:PW];

  // Delta is taken modulo 2^W and sign-extended from the active width's MSB
  assign pos_m   = cfg_q ? pos_i[PW-1:0] : {8'd0, pos_i[17:0]};
  assign diff    = pos_m - prev_q;
  assign d_ext   = cfg_q ? {{6{diff[25]}}, diff} : {{14{diff[17]}}, diff[17:0]};
  assign d_mag   = d_ext[DW-1] ? (DW'(0) - d_ext) : d_ext;
  assign is_jump = d_mag > DW'(JUMP_LIM);
  assign accept  = pos_en_i & ~pos_error_i;
  assign reject  = pos_en_i & pos_error_i;
  assign cfg_chg = cfg_spindle_width_i != cfg_q;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    prev_d     = prev_q;
    win_d      = win_q;
    sum_d      = sum_q;
    fill_d     = fill_q;
    tmo_d      = tmo_q;
    spd_pend_d = 1'b0;
    delta_en_d = 1'b0;
    delta_d    = delta_q;
    speed_en_d = 1'b0;
    speed_d    = speed_q;
    rev_d      = rev_q;
    stale_d    = stale_q;
    jump_d     = 1'b0;
    err_d      = err_q;
    warn_d     = warn_q;
    clr_win    = 1'b0;

    // Second pipeline stage: publish the window sum one cycle after the delta
    if (spd_pend_q) begin
      speed_en_d = 1'b1;
      speed_d    = sum_q;
    end

    if (!motion_en) begin
      state_d    = IDLE;
      cfg_d      = 1'b0;
      prev_d     = '0;
      tmo_d      = '0;
      speed_en_d = 1'b0;
      speed_d    = '0;
      delta_d    = '0;
      rev_d      = '0;
      stale_d    = 1'b0;
      err_d      = '0;
      warn_d     = 1'b0;
      clr_win    = 1'b1;
    end else if (cfg_chg) begin
      cfg_d   = cfg_spindle_width_i;
      state_d = PRIME;
      tmo_d   = '0;
      clr_win = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = PRIME;
        default: begin
          if (reject) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end else if (accept) begin
            tmo_d   = '0;
            stale_d = 1'b0;
            warn_d  = pos_warn_i;
            prev_d  = pos_m;
            if (state_q != TRACK) begin
              state_d = TRACK;
              clr_win = 1'b1;
            end else if (is_jump) begin
              jump_d  = 1'b1;
              clr_win = 1'b1;
            end else begin
              delta_en_d = 1'b1;
              delta_d    = d_ext;
              if (!d_ext[DW-1] && (d_ext != '0) && (pos_m < prev_q)) rev_d = rev_q + 16'd1;
              else if (d_ext[DW-1] && (pos_m > prev_q))              rev_d = rev_q - 16'd1;
              // Oldest slot stays zero until the window has filled since the last clear
              sum_d    = sum_q + d_ext - win_q[WIN-1];
              win_d[0] = d_ext;
              for (int i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
              if (fill_q != FW'(WIN)) fill_d = fill_q + FW'(1);
              spd_pend_d = fill_q >= FW'(WIN - 1);
            end
          end else if (state_q != FAULT) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
              stale_d = 1'b1;
              state_d = FAULT;
              tmo_d   = '0;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
        end
      endcase
    end

    if (clr_win) begin
      for (int i = 0; i < WIN; i++) win_d[i] = '0;
      sum_d      = '0;
      fill_d     = '0;
      spd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= 1'b0;
      prev_q     <= '0;
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      tmo_q      <= '0;
      spd_pend_q <= 1'b0;
      delta_en_q <= 1'b0;
      delta_q    <= '0;
      speed_en_q <= 1'b0;
      speed_q    <= '0;
      rev_q      <= '0;
      stale_q    <= 1'b0;
      jump_q     <= 1'b0;
      err_q      <= '0;
      warn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      prev_q     <= prev_d;
      for (int i = 0; i < WIN; i++) win_q[i] <= win_d[i];
      sum_q      <= sum_d;
      fill_q     <= fill_d;
      tmo_q      <= tmo_d;
      spd_pend_q <= spd_pend_d;
      delta_en_q <= delta_en_d;
      delta_q    <= delta_d;
      speed_en_q <= speed_en_d;
      speed_q    <= speed_d;
      rev_q      <= rev_d;
      stale_q    <= stale_d;
      jump_q     <= jump_d;
      err_q      <= err_d;
      warn_q     <= warn_d;
    end
  end

  assign delta_en_o = delta_en_q;
  assign delta_o    = delta_q;
  assign speed_en_o = speed_en_q;
  assign speed_o    = speed_q;
  assign rev_cnt_o  = rev_q;
  assign stale_o    = stale_q;
  assign jump_err_o = jump_q;
  assign err_cnt_o  = err_q;
  assign warn_o     = warn_q;

endmodule

// File: tb/tb_w_encoder_velocity_calc.sv
// Directed bench for w_encoder_velocity_calc: inputs driven and outputs sampled on negedge.
module tb_w_encoder_velocity_calc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        motion_en = 1'b0;
  logic        cfg = 1'b0;
  logic        pos_en = 1'b0;
  logic [31:0] pos = '0;
  logic        pos_err = 1'b0;
  logic        pos_warn = 1'b0;
  logic        delta_en_o, speed_en_o, stale_o, jump_err_o, warn_o;
  logic [31:0] delta_o, speed_o;
  logic [15:0] rev_cnt_o;
  logic [7:0]  err_cnt_o;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  w_encoder_velocity_calc dut (
    .clk(clk), .rst(rst), .motion_en(motion_en), .cfg_spindle_width_i(cfg),
    .pos_en_i(pos_en), .pos_i(pos), .pos_error_i(pos_err), .pos_warn_i(pos_warn),
    .delta_en_o(delta_en_o), .delta_o(delta_o), .speed_en_o(speed_en_o), .speed_o(speed_o),
    .rev_cnt_o(rev_cnt_o), .stale_o(stale_o), .jump_err_o(jump_err_o),
    .err_cnt_o(err_cnt_o), .warn_o(warn_o)
  );

  // Called on a negedge; returns on the next negedge with pos_en dropped
  task automatic send(input logic [31:0] p, input logic e, input logic w);
    pos = p; pos_err = e; pos_warn = w; pos_en = 1'b1;
    @(negedge clk);
    pos_en = 1'b0; pos_err = 1'b0; pos_warn = 1'b0;
  endtask

  task automatic restart(input logic c);
    motion_en = 1'b0; cfg = c;
    @(negedge clk);
    motion_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (delta_en_o !== 1'b0 || delta_o !== 32'd0) begin n_err++; $display("FAIL reset_delta got=%b/%0d exp=0/0", delta_en_o, delta_o); end
    n_cmp++; if (speed_en_o !== 1'b0 || speed_o !== 32'd0) begin n_err++; $display("FAIL reset_speed got=%b/%0d exp=0/0", speed_en_o, speed_o); end
    n_cmp++; if (rev_cnt_o !== 16'd0 || err_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", rev_cnt_o, err_cnt_o); end
    n_cmp++; if ({stale_o, jump_err_o, warn_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {stale_o, jump_err_o, warn_o}); end
    rst = 1'b0; motion_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    send(32'd1000, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b0) begin n_err++; $display("FAIL basic_prime_no_delta got=%b exp=0", delta_en_o); end
    send(32'd1010, 1'b0, 1'b1);
    n_cmp++; if (delta_en_o !== 1'b1) begin n_err++; $display("FAIL basic_delta_en got=%b exp=1", delta_en_o); end
    n_cmp++; if (delta_o !== 32'd10) begin n_err++; $display("FAIL basic_delta got=%0d exp=10", $signed(delta_o)); end
    n_cmp++; if (rev_cnt_o !== 16'd0) begin n_err++; $display("FAIL basic_rev got=%0d exp=0", rev_cnt_o); end
    n_cmp++; if (warn_o !== 1'b1) begin n_err++; $display("FAIL basic_warn got=%b exp=1", warn_o); end
    @(negedge clk);
    n_cmp++; if (delta_en_o !== 1'b0 || delta_o !== 32'd10) begin n_err++; $display("FAIL basic_hold got=%b/%0d exp=0/10", delta_en_o, delta_o); end
  endtask

  task automatic test_wrap;
    restart(1'b0);
    send(32'd262140, 1'b0, 1'b0);
    send(32'd4, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b1 || delta_o !== 32'd8) begin n_err++; $display("FAIL wrap_fwd_delta got=%b/%0d exp=1/8", delta_en_o, $signed(delta_o)); end
    n_cmp++; if (rev_cnt_o !== 16'd1) begin n_err++; $display("FAIL wrap_fwd_rev got=%0d exp=1", rev_cnt_o); end
    send(32'd262140, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b1 || delta_o !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_back_delta got=%b/%0d exp=1/-8", delta_en_o, $signed(delta_o)); end
    n_cmp++; if (rev_cnt_o !== 16'd0) begin n_err++; $display("FAIL wrap_back_rev got=%0d exp=0", rev_cnt_o); end
  endtask

  task automatic test_speed;
    restart(1'b1);
    send(32'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      send(32'(100 * i), 1'b0, 1'b0);
      n_cmp++; if (delta_en_o !== 1'b1 || delta_o !== 32'd100) begin n_err++; $display("FAIL speed_delta%0d got=%b/%0d exp=1/100", i, delta_en_o, delta_o); end
      n_cmp++; if (speed_en_o !== 1'b0) begin n_err++; $display("FAIL speed_early%0d got=%b exp=0", i, speed_en_o); end
      @(negedge clk);
      n_cmp++; if (speed_en_o !== (i == 16)) begin n_err++; $display("FAIL speed_en%0d got=%b exp=%b", i, speed_en_o, i == 16); end
      n_cmp++; if (speed_o !== ((i == 16) ? 32'd1600 : 32'd0)) begin n_err++; $display("FAIL speed_val%0d got=%0d exp=%0d", i, speed_o, (i == 16) ? 1600 : 0); end
    end
    send(32'd1800, 1'b0, 1'b0);
    n_cmp++; if (delta_o !== 32'd200) begin n_err++; $display("FAIL speed_d17 got=%0d exp=200", delta_o); end
    @(negedge clk);
    n_cmp++; if (speed_en_o !== 1'b1 || speed_o !== 32'd1700) begin n_err++; $display("FAIL speed_17 got=%b/%0d exp=1/1700", speed_en_o, speed_o); end
    @(negedge clk);
    n_cmp++; if (speed_en_o !== 1'b0 || speed_o !== 32'd1700) begin n_err++; $display("FAIL speed_hold got=%b/%0d exp=0/1700", speed_en_o, speed_o); end
  endtask

  task automatic test_jump;
    restart(1'b0);
    send(32'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) send(32'(i), 1'b0, 1'b0);
    send(32'd200000, 1'b0, 1'b0);
    n_cmp++; if (jump_err_o !== 1'b1) begin n_err++; $display("FAIL jump_pulse got=%b exp=1", jump_err_o); end
    n_cmp++; if (delta_en_o !== 1'b0 || delta_o !== 32'd1) begin n_err++; $display("FAIL jump_no_delta got=%b/%0d exp=0/1", delta_en_o, delta_o); end
    n_cmp++; if (rev_cnt_o !== 16'd0) begin n_err++; $display("FAIL jump_rev got=%0d exp=0", rev_cnt_o); end
    @(negedge clk);
    n_cmp++; if (jump_err_o !== 1'b0) begin n_err++; $display("FAIL jump_single got=%b exp=0", jump_err_o); end
    for (int i = 1; i <= 16; i++) begin
      send(32'(200000 + i), 1'b0, 1'b0);
      n_cmp++; if (delta_en_o !== 1'b1 || delta_o !== 32'd1) begin n_err++; $display("FAIL jump_after%0d got=%b/%0d exp=1/1", i, delta_en_o, delta_o); end
      @(negedge clk);
      n_cmp++; if (speed_en_o !== (i == 16)) begin n_err++; $display("FAIL jump_win%0d got=%b exp=%b", i, speed_en_o, i == 16); end
    end
    n_cmp++; if (speed_o !== 32'd16) begin n_err++; $display("FAIL jump_speed got=%0d exp=16", speed_o); end
  endtask

  task automatic test_timeout;
    int k;
    repeat (12490) @(negedge clk);
    n_cmp++; if (stale_o !== 1'b0) begin n_err++; $display("FAIL tmo_early got=%b exp=0", stale_o); end
    k = 0;
    while (stale_o !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_cmp++; if (stale_o !== 1'b1) begin n_err++; $display("FAIL tmo_stale got=%b exp=1 (no stale within bound)", stale_o); end
    send(32'd200100, 1'b0, 1'b0);
    n_cmp++; if (stale_o !== 1'b0 || delta_en_o !== 1'b0) begin n_err++; $display("FAIL tmo_recover got=%b/%b exp=0/0", stale_o, delta_en_o); end
    send(32'd200105, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b1 || delta_o !== 32'd5) begin n_err++; $display("FAIL tmo_delta got=%b/%0d exp=1/5", delta_en_o, delta_o); end
  endtask

  task automatic test_errors;
    for (int i = 0; i < 300; i++) begin
      send(32'd12345, 1'b1, 1'b0);
      if (i == 9) begin
        n_cmp++; if (err_cnt_o !== 8'd10) begin n_err++; $display("FAIL err_cnt10 got=%0d exp=10", err_cnt_o); end
      end
    end
    n_cmp++; if (err_cnt_o !== 8'd255) begin n_err++; $display("FAIL err_sat got=%0d exp=255", err_cnt_o); end
    n_cmp++; if (delta_en_o !== 1'b0) begin n_err++; $display("FAIL err_no_delta got=%b exp=0", delta_en_o); end
    send(32'd200110, 1'b0, 1'b1);
    n_cmp++; if (delta_en_o !== 1'b1 || delta_o !== 32'd5) begin n_err++; $display("FAIL err_prev_kept got=%b/%0d exp=1/5", delta_en_o, delta_o); end
    n_cmp++; if (warn_o !== 1'b1 || err_cnt_o !== 8'd255) begin n_err++; $display("FAIL err_warn got=%b/%0d exp=1/255", warn_o, err_cnt_o); end
    motion_en = 1'b0;
    @(negedge clk);
    n_cmp++; if ({delta_en_o, speed_en_o, stale_o, jump_err_o, warn_o} !== 5'b0) begin n_err++; $display("FAIL clr_flags got=%b exp=00000", {delta_en_o, speed_en_o, stale_o, jump_err_o, warn_o}); end
    n_cmp++; if (delta_o !== 32'd0 || speed_o !== 32'd0) begin n_err++; $display("FAIL clr_data got=%0d/%0d exp=0/0", delta_o, speed_o); end
    n_cmp++; if (err_cnt_o !== 8'd0 || rev_cnt_o !== 16'd0) begin n_err++; $display("FAIL clr_counts got=%0d/%0d exp=0/0", err_cnt_o, rev_cnt_o); end
    motion_en = 1'b1;
    @(negedge clk);
    send(32'd500, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b0) begin n_err++; $display("FAIL clr_prime got=%b exp=0", delta_en_o); end
    send(32'd507, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b1 || delta_o !== 32'd7) begin n_err++; $display("FAIL clr_track got=%b/%0d exp=1/7", delta_en_o, delta_o); end
  endtask

  task automatic test_cfg_change;
    cfg = 1'b1;
    send(32'd600, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b0) begin n_err++; $display("FAIL cfg_ignored got=%b exp=0", delta_en_o); end
    send(32'd700, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b0) begin n_err++; $display("FAIL cfg_prime got=%b exp=0", delta_en_o); end
    send(32'd710, 1'b0, 1'b0);
    n_cmp++; if (delta_en_o !== 1'b1 || delta_o !== 32'd10) begin n_err++; $display("FAIL cfg_track got=%b/%0d exp=1/10", delta_en_o, delta_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_speed();
    test_jump();
    test_timeout();
    test_errors();
    test_cfg_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/w_encoder_velocity_calc.md
W_ENCODER_VELOCITY_CALC -- requirements
Module: w_encoder_velocity_calc

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 12500, meaning the number of clk cycles without an accepted sample before stale is declared.
REQ-002 SHALL have parameter JUMP_LIM, default 4096, meaning the largest |delta| in counts accepted as plausible motion.
REQ-003 SHALL have clk, input, 1 bit: system clock, 100 MHz.
REQ-004 SHALL have rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have motion_en, input, 1 bit: when low, synchronously clears the block.
REQ-006 SHALL have cfg_spindle_width_i, input, 1 bit: position width select; 0 = 18-bit, 1 = 26-bit.
REQ-007 SHALL have pos_en_i, input, 1 bit: one-cycle strobe marking a new decoded position.
REQ-008 SHALL have pos_i, input, 32 bits: position; only bits [W-1:0] are used, where W = 18 or 26.
REQ-009 SHALL have pos_error_i and pos_warn_i, inputs, 1 bit each: encoder status flags qualified by pos_en_i.
REQ-010 SHALL have delta_en_o, output, 1 bit: strobe marking a valid delta_o.
REQ-011 SHALL have delta_o, output, 32 bits: signed position change, in counts.
REQ-012 SHALL have speed_en_o, output, 1 bit, and speed_o, output, 32 bits signed: sum of the last 16 deltas.
REQ-013 SHALL have rev_cnt_o, output, 16 bits signed: revolution count, wrapping.
REQ-014 SHALL have stale_o, output, 1 bit: level flag for a sample timeout.
REQ-015 SHALL have jump_err_o, output, 1 bit: one-cycle pulse on an implausible delta.
REQ-016 SHALL have err_cnt_o, output, 8 bits: saturating count of rejected samples.
REQ-017 SHALL have warn_o, output, 1 bit: pos_warn_i of the last accepted sample.

Function
REQ-018 SHALL use states IDLE, PRIME, TRACK and FAULT.
- IDLE goes to PRIME when motion_en=1.
- PRIME goes to TRACK on an accepted sample.
- TRACK goes to FAULT on timeout.
- FAULT goes to TRACK on an accepted sample.
REQ-019 SHALL define an accepted sample as pos_en_i=1 with pos_error_i=0.
REQ-020 SHALL handle pos_en_i=1 with pos_error_i=1 as follows: increment err_cnt_o, saturating at 255; leave prev, state and timers unchanged.
REQ-021 SHALL, on an accepted sample in PRIME or FAULT, load prev <= pos_i[W-1:0] and clear the 16-entry window, sum and fill count; no delta is emitted.
REQ-022 SHALL compute d = (pos - prev) mod 2^W and sign-extend it from bit W-1 to 32 bits.
REQ-023 SHALL, on an accepted sample in TRACK with |d| <= JUMP_LIM:
- set prev <= pos;
- assert delta_en_o=1 and delta_o=d one cycle after pos_en_i.
REQ-024 SHALL update rev_cnt_o in the same cycle as delta_en_o:
- +1 when d>0 and pos<prev;
- -1 when d<0 and pos>prev;
- 16-bit wrap.
REQ-025 SHALL, when |d| > JUMP_LIM:
- pulse jump_err_o for 1 cycle, one cycle after pos_en_i;
- set prev <= pos and clear the window;
- emit no delta and leave rev_cnt unchanged;
- remain in TRACK.
REQ-026 SHALL maintain the window as a shift buffer of the last 16 emitted deltas, with sum <= sum + new - oldest; oldest reads 0 until the buffer is full.
REQ-027 SHALL assert speed_en_o and update speed_o two cycles after pos_en_i, only once 16 deltas have been emitted since the last clear; speed_o holds its value otherwise.
REQ-028 SHALL reset the timeout counter to 0 on each accepted sample; it counts in PRIME and TRACK only.
REQ-029 SHALL, when the timeout counter reaches TIMEOUT_CYC, set stale_o=1 and enter FAULT.
REQ-030 SHALL clear stale_o on the next accepted sample.
REQ-031 SHALL register cfg_spindle_width_i and, on any change while motion_en=1, force PRIME and clear the window; a pos_en_i in that same cycle is ignored.
REQ-032 SHALL give rejection precedence over timeout when pos_en_i with error coincides with the timeout count being reached; a simultaneous accepted sample wins and stale is not set.
REQ-033 SHALL hold delta_o, warn_o and rev_cnt_o between strobes; strobes are single-cycle.

Reset
REQ-034 SHALL, on rst=1 (asynchronous) or on motion_en=0 (synchronous):
- force all outputs to 0;
- set state to IDLE;
- clear prev, window, sum, counters and the registered cfg.
REQ-035 SHALL, on rst or motion_en falling mid-sample, discard the in-flight pipeline; no strobe follows.

Verification
REQ-036 18-bit: prime with 1000, then 1010 -> delta_o=+10, rev_cnt_o=0, delta_en_o one cycle after pos_en_i.
REQ-037 18-bit wrap: prev=262140, pos=4 -> delta_o=+8, rev_cnt_o=+1; then pos=262140 -> delta_o=-8, rev_cnt_o=0.
REQ-038 26-bit: 16 samples stepping +100 after prime -> speed_en_o on the 16th delta only, speed_o=1600; 17th step +200 -> speed_o=1700.
REQ-039 TRACK, prev=0, pos=5000 -> jump_err_o pulse, no delta_en_o, window cleared, rev_cnt_o unchanged.
REQ-040 No pos_en_i for 12500 cycles in TRACK -> stale_o=1, FAULT; next accepted sample -> stale_o=0, no delta; following sample -> delta emitted.
REQ-041 300 samples with pos_error_i=1 -> err_cnt_o=255, prev unchanged; motion_en low for 1 cycle -> all outputs 0, state IDLE.
